// File: rtl/fft_lane_rotator.sv
// fft_lane_rotator: rotates LANES complex samples by iSEL in direction iDIR behind a
// registered valid/ready stage with a 2-entry skid buffer. Optional macro FFT_ROT_CONJ_EN
// adds iCONJ, which negates the imag lanes with saturation.
module fft_lane_rotator #(
  parameter int BIT = 17,
  parameter int LANES = 4,
  localparam int SELW = $clog2(LANES)
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic [SELW-1:0]      iSEL,
  input  logic                 iDIR,
`ifdef FFT_ROT_CONJ_EN
  input  logic                 iCONJ,
`endif
  input  logic [LANES*BIT-1:0] iX_RE,
  input  logic [LANES*BIT-1:0] iX_IM,
  input  logic                 iVALID,
  output logic                 oREADY,
  output logic [LANES*BIT-1:0] oY_RE,
  output logic [LANES*BIT-1:0] oY_IM,
  output logic                 oVALID,
  input  logic                 iREADY,
  output logic [15:0]          oBEATS
);
  // The state code is {oVALID, skdV}; the code 01 never occurs.
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;
  state_t state, stateNext;
  logic [LANES*BIT-1:0] rotRe, rotIm, skdRe, skdIm;
  logic accept, consume;
  assign accept = iVALID && oREADY;
  assign consume = oVALID && iREADY;
  assign oVALID = state[1];
`ifdef FFT_ROT_CONJ_EN
  localparam logic [BIT-1:0] MINV = {1'b1, {(BIT-1){1'b0}}};
  function automatic logic [BIT-1:0] satNeg(input logic [BIT-1:0] v);
    return (v == MINV) ? ~MINV : -v;
  endfunction
`endif
  // Select each output lane from its source lane; the index wraps modulo LANES.
  always_comb begin
    logic [SELW-1:0] idx;
    logic [BIT-1:0] im;
    rotRe = '0;
    rotIm = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = iDIR ? SELW'(k) + iSEL : SELW'(k) - iSEL;
      im = iX_IM[idx*BIT +: BIT];
      rotRe[k*BIT +: BIT] = iX_RE[idx*BIT +: BIT];
`ifdef FFT_ROT_CONJ_EN
      rotIm[k*BIT +: BIT] = iCONJ ? satNeg(im) : im;
`else
      rotIm[k*BIT +: BIT] = im;
`endif
    end
  end
  // Next occupancy from the input and output handshakes.
  always_comb begin
    stateNext = state;
    if (state == EMPTY) stateNext = accept ? ONE : EMPTY;
    else if (state == ONE) stateNext = (accept && !consume) ? FULL : (!accept && consume) ? EMPTY : ONE;
    else stateNext = consume ? ONE : FULL;
  end
  // Occupancy and registered ready, which tracks the next skid state.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state <= EMPTY;
      oREADY <= 1'b0;
    end else begin
      state <= stateNext;
      oREADY <= (stateNext != FULL);
    end
  end
  // The output register loads from the skid buffer when draining, or else from the rotator.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      oY_RE <= '0;
      oY_IM <= '0;
    end else if (state == FULL) begin
      if (consume) begin
        oY_RE <= skdRe;
        oY_IM <= skdIm;
      end
    end else if (accept && (!oVALID || consume)) begin
      oY_RE <= rotRe;
      oY_IM <= rotIm;
    end
  end
  // The skid buffer captures a beat that arrives while the output is stalled.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      skdRe <= '0;
      skdIm <= '0;
    end else if (state == ONE && accept && !consume) begin
      skdRe <= rotRe;
      skdIm <= rotIm;
    end
  end
  // Count accepted input beats; the counter wraps silently.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) oBEATS <= '0;
    else if (accept) oBEATS <= oBEATS + 16'd1;
  end
endmodule

// File: tb/tb_fft_lane_rotator.sv
// tb_fft_lane_rotator: directed checks of rotation, streaming, backpressure and reset.
module tb_fft_lane_rotator;
  logic iCLK = 1'b0, iRESET = 1'b0;
  always #5 iCLK = ~iCLK;
  logic [1:0] sel4 = '0;
  logic dir4 = 1'b0, v4 = 1'b0, ir4 = 1'b1, rdy4, ov4;
  logic [67:0] xre4 = '0, xim4 = '0, yre4, yim4;
  logic [15:0] beats4;
  logic [2:0] sel8 = '0;
  logic dir8 = 1'b0, v8 = 1'b0, rdy8, ov8;
  logic [135:0] xre8 = '0, xim8 = '0, yre8, yim8;
  logic [15:0] beats8;
`ifdef FFT_ROT_CONJ_EN
  logic conj4 = 1'b0;
`endif
  int nChk = 0, nErr = 0;

  fft_lane_rotator #(.BIT(17), .LANES(4)) d4 (
    .iCLK(iCLK), .iRESET(iRESET), .iSEL(sel4), .iDIR(dir4),
`ifdef FFT_ROT_CONJ_EN
    .iCONJ(conj4),
`endif
    .iX_RE(xre4), .iX_IM(xim4), .iVALID(v4), .oREADY(rdy4),
    .oY_RE(yre4), .oY_IM(yim4), .oVALID(ov4), .iREADY(ir4), .oBEATS(beats4));

  fft_lane_rotator #(.BIT(17), .LANES(8)) d8 (
    .iCLK(iCLK), .iRESET(iRESET), .iSEL(sel8), .iDIR(dir8),
`ifdef FFT_ROT_CONJ_EN
    .iCONJ(1'b0),
`endif
    .iX_RE(xre8), .iX_IM(xim8), .iVALID(v8), .oREADY(rdy8),
    .oY_RE(yre8), .oY_IM(yim8), .oVALID(ov8), .iREADY(1'b1), .oBEATS(beats8));

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [67:0] p4(input int a, input int b, input int c, input int d);
    return {17'(d), 17'(c), 17'(b), 17'(a)};
  endfunction

  function automatic logic [135:0] p8(input int a, input int b, input int c, input int d,
                                      input int e, input int f, input int g, input int h);
    return {17'(h), 17'(g), 17'(f), 17'(e), 17'(d), 17'(c), 17'(b), 17'(a)};
  endfunction

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic send4(input int s, input logic d, input logic [67:0] re, input logic [67:0] im);
    sel4 = 2'(s);
    dir4 = d;
    xre4 = re;
    xim4 = im;
    v4 = 1'b1;
  endtask

  initial begin
    #2;
    chk("rst_ready", 136'(rdy4), 136'(0));
    chk("rst_valid", 136'(ov4), 136'(0));
    chk("rst_beats", 136'(beats4), 136'(0));
    chk("rst_yre", 136'(yre4), 136'(0));
    #10 iRESET = 1'b1;
    step();
    chk("rel_ready", 136'(rdy4), 136'(1));
    chk("rel_valid", 136'(ov4), 136'(0));

    send4(1, 1'b0, p4(1, 2, 3, 4), p4(10, 20, 30, 40));
    step();
    v4 = 1'b0;
    chk("rot4_valid", 136'(ov4), 136'(1));
    chk("rot4_re", 136'(yre4), 136'(p4(4, 1, 2, 3)));
    chk("rot4_im", 136'(yim4), 136'(p4(40, 10, 20, 30)));
    chk("rot4_beats", 136'(beats4), 136'(1));
    step();
    chk("rot4_drain", 136'(ov4), 136'(0));

    sel8 = 3'd3; dir8 = 1'b1; xre8 = p8(0, 1, 2, 3, 4, 5, 6, 7); v8 = 1'b1;
    step();
    chk("rot8_dir1", yre8, p8(3, 4, 5, 6, 7, 0, 1, 2));
    sel8 = 3'd0; dir8 = 1'b0;
    step();
    chk("rot8_sel0_dir0", yre8, p8(0, 1, 2, 3, 4, 5, 6, 7));
    dir8 = 1'b1; xre8 = p8(9, 8, 7, 6, 5, 4, 3, 2);
    step();
    v8 = 1'b0;
    chk("rot8_sel0_dir1", yre8, p8(9, 8, 7, 6, 5, 4, 3, 2));
    chk("rot8_beats", 136'(beats8), 136'(3));

    ir4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send4(0, i[0], p4(4*i+1, 4*i+2, 4*i+3, 4*i+4), '0);
      step();
      chk($sformatf("stream_valid%0d", i), 136'(ov4), 136'(1));
      chk($sformatf("stream_re%0d", i), 136'(yre4), 136'(p4(4*i+1, 4*i+2, 4*i+3, 4*i+4)));
      chk($sformatf("stream_ready%0d", i), 136'(rdy4), 136'(1));
    end
    v4 = 1'b0;
    chk("stream_beats", 136'(beats4), 136'(11));
    step();
    chk("stream_drain", 136'(ov4), 136'(0));

    ir4 = 1'b0;
    send4(2, 1'b1, p4(1, 2, 3, 4), '0);
    step();
    chk("bp_a_out", 136'(yre4), 136'(p4(3, 4, 1, 2)));
    chk("bp_a_ready", 136'(rdy4), 136'(1));
    send4(3, 1'b0, p4(5, 6, 7, 8), '0);
    step();
    chk("bp_b_ready", 136'(rdy4), 136'(0));
    chk("bp_a_held", 136'(yre4), 136'(p4(3, 4, 1, 2)));
    send4(1, 1'b1, p4(9, 10, 11, 12), '0);
    step();
    chk("bp_c_wait_ready", 136'(rdy4), 136'(0));
    chk("bp_c_wait_out", 136'(yre4), 136'(p4(3, 4, 1, 2)));
    chk("bp_c_wait_beats", 136'(beats4), 136'(13));
    ir4 = 1'b1;
    step();
    chk("bp_b_out", 136'(yre4), 136'(p4(6, 7, 8, 5)));
    chk("bp_ready_back", 136'(rdy4), 136'(1));
    step();
    v4 = 1'b0;
    chk("bp_c_out", 136'(yre4), 136'(p4(10, 11, 12, 9)));
    chk("bp_c_valid", 136'(ov4), 136'(1));
    step();
    chk("bp_drain", 136'(ov4), 136'(0));
    chk("bp_beats", 136'(beats4), 136'(14));

    ir4 = 1'b0;
    send4(0, 1'b0, p4(100, 101, 102, 103), p4(1, 1, 1, 1));
    step();
    send4(0, 1'b0, p4(200, 201, 202, 203), p4(2, 2, 2, 2));
    step();
    chk("full_ready", 136'(rdy4), 136'(0));
    iRESET = 1'b0;
    #1;
    chk("rstfull_valid", 136'(ov4), 136'(0));
    chk("rstfull_yre", 136'(yre4), 136'(0));
    chk("rstfull_yim", 136'(yim4), 136'(0));
    chk("rstfull_beats", 136'(beats4), 136'(0));
    chk("rstfull_ready", 136'(rdy4), 136'(0));
    v4 = 1'b0;
    ir4 = 1'b1;
    #2 iRESET = 1'b1;
    step();
    chk("rstfull_rel_ready", 136'(rdy4), 136'(1));
    chk("rstfull_rel_valid", 136'(ov4), 136'(0));
    send4(1, 1'b0, p4(21, 22, 23, 24), '0);
    step();
    v4 = 1'b0;
    chk("post_rst_re", 136'(yre4), 136'(p4(24, 21, 22, 23)));
    chk("post_rst_beats", 136'(beats4), 136'(1));
    step();
    chk("post_rst_no_stale", 136'(ov4), 136'(0));

`ifdef FFT_ROT_CONJ_EN
    conj4 = 1'b1;
    send4(0, 1'b0, p4(1, 2, 3, 4), p4(5, -65536, 0, -7));
    step();
    v4 = 1'b0;
    conj4 = 1'b0;
    chk("conj_im", 136'(yim4), 136'(p4(-5, 65535, 0, 7)));
    chk("conj_re", 136'(yre4), 136'(p4(1, 2, 3, 4)));
    step();
`endif

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end
endmodule

// File: doc/fft_lane_rotator.md
Name: fft_lane_rotator

Overview:
- Parametrised lane-rotation stage in front of the radix-4/radix-2^k butterfly banks. Rotates LANES complex samples by a run-time amount in either direction.
- Registers the result with a valid/ready handshake and a 2-entry skid buffer, so the butterfly array can stall without losing data.
- Generalises the fixed 4-lane, 2-bit-select input mixer. With LANES=4 and iDIR=0 it reproduces that mapping.

Parameters:
BIT, 17, width of each real/imag component (two's complement)
LANES, 4, number of complex lanes; power of two, 2..16
SELW, $clog2(LANES), width of the rotation amount (derived, do not override)

Ports:
iCLK  in  1  clock
iRESET  in  1  reset, asynchronous, active-low
iSEL  in  SELW  rotation amount, sampled with the input beat
iDIR  in  1  0: Y[k]=X[(k-SEL) mod LANES]; 1: Y[k]=X[(k+SEL) mod LANES]
iX_RE  in  LANES*BIT  input real parts; lane k at [k*BIT +: BIT]
iX_IM  in  LANES*BIT  input imag parts, same packing
iVALID  in  1  input beat valid
oREADY  out  1  block can accept a beat this cycle
oY_RE  out  LANES*BIT  rotated real parts, same packing
oY_IM  out  LANES*BIT  rotated imag parts
oVALID  out  1  output beat valid
iREADY  in  1  downstream accepts the output beat
oBEATS  out  16  count of beats accepted at the input, wraps at 65535->0

Behaviour:
- Reset (async, iRESET low): all outputs 0, except oREADY=0 while reset is asserted.
  - Skid register empty, oBEATS=0.
  - oREADY goes to 1 on the first iCLK edge after release.
  - Reset mid-operation discards the output register and the skid contents. No partial beat survives.
- Input handshake: a beat is accepted on a rising edge with iVALID&&oREADY. Output handshake: a beat is consumed on a rising edge with oVALID&&iREADY.
- Rotation is combinational on the input side; the result is registered. Latency is 1 cycle from acceptance to oVALID when not stalled.
- iSEL=0 is pass-through for both iDIR values. iSEL and iDIR are captured per beat; changing them between beats has no glitch effect.
- Storage:
  - Output register OUT: oY_*, oVALID.
  - Skid register SKD: data plus skd_v.
  - oREADY = !skd_v, registered (no combinational path from iREADY to oREADY).
- States are encoded by (oVALID, skd_v): EMPTY(0,0), ONE(1,0), FULL(1,1). State (0,1) is illegal and is never reached.
  - EMPTY: accept -> ONE, rotated data loads OUT.
  - ONE:
    - accept && consume -> ONE, OUT reloaded.
    - accept && !consume -> FULL, new beat goes to SKD.
    - !accept && consume -> EMPTY.
    - otherwise hold.
  - FULL (oREADY=0): consume -> ONE, SKD moves to OUT, skd_v clears. Otherwise hold.
- Simultaneous accept and consume in ONE gives full throughput: 1 beat per cycle indefinitely with iREADY=1.
- While oVALID=1 && !iREADY, oY_* holds stable.
- Beat order is strictly preserved.
- oBEATS increments on each accepted beat and wraps silently.
- No arithmetic on data except under the optional feature. Widths pass through unchanged.

Optional Feature:
- Macro FFT_ROT_CONJ_EN.
- When defined:
  - Extra input iCONJ (1 bit), sampled per beat with iSEL.
  - When iCONJ=1, each output imag lane is negated with saturation: -(-2^(BIT-1)) gives 2^(BIT-1)-1.
  - Real lanes and latency are unchanged.
- When undefined: no iCONJ port and no negation logic; imag passes through.

Test Plan:
- LANES=4, iDIR=0, iSEL=1, X lanes RE=1,2,3,4, one beat with iREADY=1 -> one cycle later oVALID=1, oY_RE lanes=4,1,2,3; oBEATS=1.
- LANES=8, iDIR=1, iSEL=3, lanes RE=0..7 -> oY_RE lanes=3,4,5,6,7,0,1,2. iSEL=0 with either iDIR -> lanes unchanged.
- Stream of 10 beats with iVALID=1, iREADY=1 -> oVALID continuous from cycle 1, data in order, oREADY never drops, oBEATS=10.
- Backpressure: iREADY=0 while sending beats A,B,C -> A held on output, B in skid, oREADY=0 from the cycle after B, C waits. iREADY=1 -> A,B,C emerge on consecutive cycles and oREADY returns to 1.
- Reset asserted in FULL state -> oVALID=0, oY_*=0, oBEATS=0 immediately. After release, the next beat outputs with 1-cycle latency and contains no stale data.
- FFT_ROT_CONJ_EN defined, BIT=17, iCONJ=1, IM lanes=5,-65536,0,-7 with iSEL=0 -> oY_IM lanes=-5,65535,0,7.
